// File: rtl/tdm_slot_mux.sv
// TDM slot multiplexer: divides each frame of the free-running down-counter into NUM_CH slots and
// forwards the granted channel's beats onto one output. Define TDM_FRAME_CHECK_EN to enable counter-sequence checking.
module tdm_slot_mux #(
    parameter int  FRAME_COUNT = 255,
    parameter int  NUM_CH      = 4,
    parameter int  GUARD       = 2,
    parameter int  DW          = 8,
    localparam int SLOT_LEN    = (FRAME_COUNT + 1) / NUM_CH,
    localparam int CW          = $clog2(FRAME_COUNT) + 1,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        cnt_in,
    input  logic [NUM_CH-1:0]    s_valid,
    input  logic [NUM_CH*DW-1:0] s_data,
    output logic [NUM_CH-1:0]    s_ready,
    output logic                 m_valid,
    output logic [DW-1:0]        m_data,
    output logic [CHW-1:0]       m_chan,
    output logic                 m_sos,
    output logic                 m_sof,
    output logic                 sync_err
);

    localparam int PW       = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam int OPEN_LEN = SLOT_LEN - GUARD;

    if ((FRAME_COUNT + 1) % NUM_CH != 0) begin : g_bad_num_ch
        $error("tdm_slot_mux: FRAME_COUNT+1 must be a multiple of NUM_CH");
    end
    if (GUARD < 0 || GUARD >= SLOT_LEN) begin : g_bad_guard
        $error("tdm_slot_mux: GUARD must satisfy 0 <= GUARD < SLOT_LEN");
    end

    typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_t;

    state_t          state;
    logic [CHW-1:0]  slot;
    logic [PW-1:0]   pos;
    logic            at_top;
    logic            seq_bad;
    logic            active;
    logic            open;
    logic            transfer;
    logic [CHW-1:0]  cur_slot;
    logic [PW-1:0]   cur_pos;
    logic [CHW-1:0]  next_slot;
    logic [PW-1:0]   next_pos;
    logic [DW-1:0]   sel_data;

`ifdef TDM_FRAME_CHECK_EN
    logic [CW-1:0]   prev_cnt;
    logic [CW-1:0]   exp_cnt;
`endif

    // Slot position for this cycle, grant window, and the successor position.
    always_comb begin
        at_top = (cnt_in == CW'(FRAME_COUNT));
`ifdef TDM_FRAME_CHECK_EN
        exp_cnt = (prev_cnt == '0) ? CW'(FRAME_COUNT) : (prev_cnt - CW'(1));
        seq_bad = (state == SYNC) && (cnt_in != exp_cnt);
`else
        seq_bad = 1'b0;
`endif
        active   = (state == SYNC) && !seq_bad;
        // The counter top value always marks slot 0, position 0 (resync point).
        cur_slot = at_top ? '0 : slot;
        cur_pos  = at_top ? '0 : pos;
        open     = active && (int'(cur_pos) < OPEN_LEN);
        s_ready  = open ? (NUM_CH'(1) << cur_slot) : '0;
        transfer = open && s_valid[cur_slot];
        sel_data = s_data[cur_slot*DW +: DW];
        if (cur_pos == PW'(SLOT_LEN - 1)) begin
            next_pos  = '0;
            next_slot = (cur_slot == CHW'(NUM_CH - 1)) ? '0 : (cur_slot + CHW'(1));
        end else begin
            next_pos  = cur_pos + PW'(1);
            next_slot = cur_slot;
        end
    end

    // Sync FSM, slot/position tracking and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNSYNC;
            slot     <= '0;
            pos      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_chan   <= '0;
            m_sos    <= 1'b0;
            m_sof    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            case (state)
                UNSYNC: begin
                    if (at_top) begin
                        state <= SYNC;
                        slot  <= next_slot;
                        pos   <= next_pos;
                    end
                end
                SYNC: begin
                    if (seq_bad) begin
                        state <= UNSYNC;
                    end else begin
                        slot <= next_slot;
                        pos  <= next_pos;
                    end
                end
                default: state <= UNSYNC;
            endcase
            m_valid  <= transfer;
            if (transfer) begin
                m_data <= sel_data;
                m_chan <= cur_slot;
            end
            m_sos    <= active && (cur_pos == '0);
            m_sof    <= active && (cur_pos == '0) && (cur_slot == '0);
            sync_err <= seq_bad;
        end
    end

`ifdef TDM_FRAME_CHECK_EN
    // Previous counter value for the sequence check.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cnt <= '0;
        end else begin
            prev_cnt <= cnt_in;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_slot_mux.sv
// Self-checking bench for tdm_slot_mux: a hand-computed startup table, then randomized and directed
// traffic checked against a frame-phase reference model.
module tb_tdm_slot_mux;
    localparam int FC  = 15;
    localparam int NCH = 4;
    localparam int G   = 1;
    localparam int DW  = 8;
    localparam int SL  = (FC + 1) / NCH;
    localparam int CW  = 5;
    localparam int CHW = 2;

    logic               clk = 1'b1;
    logic               rst;
    logic [CW-1:0]      cnt_in;
    logic [NCH-1:0]     s_valid;
    logic [NCH*DW-1:0]  s_data;
    logic [NCH-1:0]     s_ready;
    logic               m_valid;
    logic [DW-1:0]      m_data;
    logic [CHW-1:0]     m_chan;
    logic               m_sos, m_sof, sync_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_slot_mux #(.FRAME_COUNT(FC), .NUM_CH(NCH), .GUARD(G), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_chan(m_chan),
        .m_sos(m_sos), .m_sof(m_sof), .sync_err(sync_err)
    );

    // Reference model: one phase index 0..FC within the frame instead of slot/position registers.
    bit md_sync = 1'b0;
    int md_phase = 0;
    int md_prev = 0;
    bit md_mv = 1'b0, md_sos = 1'b0, md_sof = 1'b0, md_err = 1'b0;
    int md_data = 0, md_chan = 0;
    int cnt_src = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cnt_in=%0d t=%0t)", name, act, exp, cnt_in, $time);
        end
    endtask

    function automatic bit model_bad();
`ifdef TDM_FRAME_CHECK_EN
        return md_sync && (int'(cnt_in) != ((md_prev == 0) ? FC : md_prev - 1));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        int ph;
        logic [NCH-1:0] r;
        r = '0;
        if (md_sync && !model_bad()) begin
            ph = (int'(cnt_in) == FC) ? 0 : md_phase;
            if ((ph % SL) < SL - G) r[ph / SL] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_step();
        int ph;
        bit bad, act;
        logic [NCH-1:0] r;
        if (rst) begin
            md_sync = 1'b0; md_phase = 0;
            md_mv = 1'b0; md_sos = 1'b0; md_sof = 1'b0; md_err = 1'b0;
            md_data = 0; md_chan = 0;
        end else begin
            bad = model_bad();
            r   = model_ready();
            act = md_sync && !bad;
            ph  = (int'(cnt_in) == FC) ? 0 : md_phase;
            md_sos = act && (ph % SL == 0);
            md_sof = act && (ph == 0);
            md_err = bad;
            md_mv  = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (r[k] && s_valid[k]) begin
                    md_mv = 1'b1; md_data = int'(s_data[k*DW +: DW]); md_chan = k;
                end
            end
            if (!md_sync) begin
                if (int'(cnt_in) == FC) begin md_sync = 1'b1; md_phase = 1; end
            end else if (bad) begin
                md_sync = 1'b0;
            end else begin
                md_phase = (ph + 1) % (FC + 1);
            end
        end
        md_prev = int'(cnt_in);
    endtask

    // Wait to the falling edge, optionally compare against the model, then advance the model.
    task automatic sample(input bit do_chk);
        @(negedge clk);
        if (do_chk) begin
            chk("s_ready", int'(s_ready), int'(model_ready()));
            chk("m_valid", int'(m_valid), int'(md_mv));
            chk("m_data", int'(m_data), md_data);
            chk("m_chan", int'(m_chan), md_chan);
            chk("m_sos", int'(m_sos), int'(md_sos));
            chk("m_sof", int'(m_sof), int'(md_sof));
            chk("sync_err", int'(sync_err), int'(md_err));
        end
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cnt();
        cnt_in  = CW'(cnt_src);
        cnt_src = (cnt_src == 0) ? FC : cnt_src - 1;
    endtask

    typedef struct {
        logic           rst;
        logic [CW-1:0]  cnt;
        logic [NCH-1:0] rdy;
        logic           mv;
        logic [CHW-1:0] ch;
        logic [DW-1:0]  dat;
        logic           sos;
        logic           sof;
        logic           chk;
    } row_t;

    row_t tbl[21];
    int   err_cnt;
    bit   found;

    initial begin
        // Startup from reset with all channels valid, data A0+k.
        tbl[0]  = '{1'b1, 5'd2,  4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 5'd1,  4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 5'd0,  4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 5'd15, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 5'd14, 4'h1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 5'd13, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 5'd12, 4'h0, 1'b1, 2'd0, 8'hA0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 5'd11, 4'h2, 1'b0, 2'd0, 8'hA0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd10, 4'h2, 1'b1, 2'd1, 8'hA1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 5'd9,  4'h2, 1'b1, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'd8,  4'h0, 1'b1, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd7,  4'h4, 1'b0, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd6,  4'h4, 1'b1, 2'd2, 8'hA2, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 5'd5,  4'h4, 1'b1, 2'd2, 8'hA2, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 5'd4,  4'h0, 1'b1, 2'd2, 8'hA2, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'd3,  4'h8, 1'b0, 2'd2, 8'hA2, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 5'd2,  4'h8, 1'b1, 2'd3, 8'hA3, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 5'd1,  4'h8, 1'b1, 2'd3, 8'hA3, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 5'd0,  4'h0, 1'b1, 2'd3, 8'hA3, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 5'd15, 4'h1, 1'b0, 2'd3, 8'hA3, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 5'd14, 4'h1, 1'b1, 2'd0, 8'hA0, 1'b1, 1'b1, 1'b1};

        s_valid = 4'hF;
        s_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 21; i++) begin
            rst    = tbl[i].rst;
            cnt_in = tbl[i].cnt;
            @(negedge clk);
            if (tbl[i].chk) begin
                chk("tbl_s_ready", int'(s_ready), int'(tbl[i].rdy));
                chk("tbl_m_valid", int'(m_valid), int'(tbl[i].mv));
                chk("tbl_m_chan", int'(m_chan), int'(tbl[i].ch));
                chk("tbl_m_data", int'(m_data), int'(tbl[i].dat));
                chk("tbl_m_sos", int'(m_sos), int'(tbl[i].sos));
                chk("tbl_m_sof", int'(m_sof), int'(tbl[i].sof));
                chk("tbl_sync_err", int'(sync_err), 0);
            end
            model_step();
            advance();
        end
        cnt_src = 13;

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            drive_cnt();
            s_valid = NCH'($urandom);
            s_data  = (NCH*DW)'($urandom);
            sample(1'b1);
            advance();
        end

        // Reset at slot 1 position 2 (counter value 9).
        for (int i = 0; i < 17 && cnt_src != 9; i++) begin
            drive_cnt(); sample(1'b1); advance();
        end
        drive_cnt();
        rst = 1'b1;
        s_valid = 4'hF;
        sample(1'b1);
        advance();
        rst = 1'b0;
        drive_cnt();
        sample(1'b1);
        chk("rst_outputs_zero", int'({m_valid, m_data, m_chan, m_sos, m_sof, sync_err}), 0);
        advance();
        for (int i = 0; i < 20 && cnt_src != FC; i++) begin
            drive_cnt(); sample(1'b1);
            chk("rst_no_grant", int'(s_ready), 0);
            advance();
        end

        // Only channel 2 valid, raised during slot 0; held until slot 2 opens.
        s_valid = 4'b0000;
        s_data  = {8'h33, 8'h5C, 8'h11, 8'h00};
        found   = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            drive_cnt();
            if (int'(cnt_in) == FC) s_valid = 4'b0100;
            sample(1'b1);
            if (m_valid) begin
                found = 1'b1;
                chk("ch2_first_beat_cnt", int'(cnt_in), 6);
                chk("ch2_first_beat_chan", int'(m_chan), 2);
            end
            advance();
        end
        chk("ch2_beat_seen", int'(found), 1);

        // Counter glitch: 9 followed by 5 instead of 8.
        s_valid = 4'hF;
        for (int i = 0; i < 17 && cnt_src != 9; i++) begin
            drive_cnt(); sample(1'b1); advance();
        end
        drive_cnt(); sample(1'b1); advance();
        drive_cnt();
        cnt_in  = CW'(5);
        err_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) drive_cnt();
            sample(1'b1);
            if (sync_err) err_cnt++;
            advance();
        end
`ifdef TDM_FRAME_CHECK_EN
        chk("sync_err_pulses", err_cnt, 1);
`else
        chk("sync_err_pulses", err_cnt, 0);
`endif

        for (int i = 0; i < 100; i++) begin
            drive_cnt();
            s_valid = NCH'($urandom);
            s_data  = (NCH*DW)'($urandom);
            sample(1'b1);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
